ext_int_ctrl: RTL

- Memory-mapped external-interrupt source on the MIPS microsystem data bus; the bus responder and interrupt raiser that the CPU acknowledges.
- CPU programs a countdown or arms an external trigger. Block raises `interrupt` and holds it until the handler writes the ACK register at 0x7f20.
- Sits behind the bridge beside the timers. Replaces the bench's ad-hoc interrupt stimulus with synthesizable RTL.

---
 rtl/ext_int_ctrl_pkg.sv | 41 ++++
 rtl/ext_int_ctrl_sync_edge_det.sv | 28 ++
 rtl/ext_int_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ext_int_ctrl_pkg.sv
// Shared definitions for the external-interrupt controller: register map, CTRL layout, FSM states.
package ext_int_ctrl_pkg;

  localparam logic [31:0] BASE_DEFAULT  = 32'h0000_7f20;
  localparam int unsigned CNT_W_DEFAULT = 32;

  // Word selects within the 16-byte window (addr[3:2])
  localparam logic [1:0] OFF_ACK    = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_PRESET = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_EXT_EN   = 2;

  typedef struct packed {
    logic ext_en;
    logic periodic;
    logic en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

  // Replace only the bytes selected by be
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ext_int_ctrl_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous line plus a one-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic rise_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the raw line and keep one cycle of history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/ext_int_ctrl.sv
// Memory-mapped interrupt source: programmable countdown or external trigger, held until ACK.
module ext_int_ctrl
  import ext_int_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE  = BASE_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  input  logic        ext_trig,
  output logic        interrupt
);

  logic             hit;
  logic [1:0]       sel;
  logic             wr;
  logic             ack_wr;
  logic             ctrl_wr;
  logic             preset_wr;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_new;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_load;
  state_e           state_q;
  state_e           state_d;
  logic             missed_q;
  logic             missed_d;
  logic             irq_d;
  logic             clr_en;
  logic             ext_rise_c;
  logic             ext_ok;
  logic             unused_addr_lsb;

  assign hit        = (addr[31:4] == BASE[31:4]);
  assign sel        = addr[3:2];
  assign wr         = hit && (byteen != 4'h0);
  assign ack_wr     = wr && (sel == OFF_ACK);
  assign ctrl_wr    = wr && (sel == OFF_CTRL);
  assign preset_wr  = wr && (sel == OFF_PRESET);
  assign count_load = (preset_q == '0) ? CNT_W'(1) : preset_q;
  assign ext_ok     = ext_rise_c & ctrl_q.en & ctrl_q.ext_en;
  assign unused_addr_lsb = ^addr[1:0];

  sync_edge_det u_ext_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (ext_trig),
    .rise_c  (ext_rise_c)
  );

  // CTRL value that a write this cycle would leave behind (only byte 0 holds bits)
  always_comb begin
    ctrl_new = ctrl_q;
    if (byteen[0]) begin
      ctrl_new.en       = wdata[CTRL_EN];
      ctrl_new.periodic = wdata[CTRL_PERIODIC];
      ctrl_new.ext_en   = wdata[CTRL_EXT_EN];
    end
  end

  // Software-visible configuration registers; one-shot ACK clears EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q <= ctrl_new;
      end else if (clr_en) begin
        ctrl_q.en <= 1'b0;
      end
      if (preset_wr) begin
        preset_q <= CNT_W'(byte_merge(32'(preset_q), wdata, byteen));
      end
    end
  end

  // FSM state, counter, sticky MISSED and registered interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      missed_q  <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      missed_q  <= missed_d;
      interrupt <= irq_d;
    end
  end

  // Next-state: disabling CTRL write wins, then per-state countdown / trigger / ACK handling
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    missed_d = missed_q;
    clr_en   = 1'b0;
    if (ctrl_wr && !ctrl_new.en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ext_ok) begin
            state_d = ST_PENDING;
          end else if (ctrl_q.en) begin
            state_d = ST_COUNT;
            count_d = count_load;
          end
        end
        ST_COUNT: begin
          if (ext_ok) begin
            state_d = ST_PENDING;
          end else if (count_q <= CNT_W'(1)) begin
            state_d = ST_PENDING;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (ack_wr) begin
            missed_d = 1'b0;
            if (ctrl_q.periodic && ctrl_q.en) begin
              state_d = ST_COUNT;
              count_d = count_load;
            end else begin
              state_d = ST_IDLE;
              clr_en  = 1'b1;
            end
          end else if (ext_ok) begin
            missed_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    irq_d = (state_d == ST_PENDING);
  end

  // Combinational read mux; zero outside the window
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        OFF_CTRL:   rdata = {29'd0, ctrl_q};
        OFF_PRESET: rdata = 32'(preset_q);
        OFF_STATUS: rdata = {count_q[15:0], 13'd0, missed_q, state_q};
        default:    rdata = '0;
      endcase
    end
  end

endmodule
